// File: rtl/dmem_access_ctrl_if.sv
// Memory-side bus of the data-memory access controller: level request with
// single-cycle acknowledge. The controller is the master; the memory is the slave.
interface dmem_access_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: runs one load/store per EX/MEM instruction
// over the request/ack bus, stalling the pipeline until the access resolves.
//
// state | meaning
// IDLE  | waiting for an aligned load/store in EX/MEM
// BUSY  | request on the bus, waiting for ack or timeout
// DONE  | one-cycle release; pipeline advances, read result valid
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic [31:0]        Addr_i,
  input  logic [31:0]        WrData_i,
  output logic               stall_o,
  output logic [31:0]        RdData_o,
  output logic               RdValid_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   rd_cnt_o,
  output logic [CNT_W-1:0]   wr_cnt_o,
  dmem_access_ctrl_if.master mem_if
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             rd_ok_q, rd_ok_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             stall_d;
  logic             access;
  logic             aligned;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (Addr_i[1:0] == 2'b00);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    rd_ok_d  = rd_ok_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    stall_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall_d = 1'b1;
            we_d    = MemWrite_i;
            addr_d  = Addr_i;
            wdata_d = WrData_i;
            tmo_d   = 8'd0;
            rd_ok_d = 1'b0;
            state_d = BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_d = 1'b1;
        tmo_d   = tmo_q + 8'd1;
        // An ack on the final allowed cycle still completes the access.
        if (mem_if.mem_ack_i) begin
          state_d = DONE;
          if (we_q) begin
            if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
          end else begin
            rdata_d = mem_if.mem_rdata_i;
            rd_ok_d = 1'b1;
            if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      tmo_q    <= 8'd0;
      rd_ok_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      rd_ok_q  <= rd_ok_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // The IDLE stall is combinational from the inputs, so gate it while in reset.
  assign stall_o            = stall_d & rst_i;
  assign RdData_o           = rdata_q;
  assign RdValid_o          = (state_q == DONE) & rd_ok_q;
  assign err_o              = err_q;
  assign rd_cnt_o           = rd_cnt_q;
  assign wr_cnt_o           = wr_cnt_q;
  assign mem_if.mem_req_o   = (state_q == BUSY);
  assign mem_if.mem_we_o    = we_q;
  assign mem_if.mem_addr_o  = addr_q;
  assign mem_if.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected bus requests and read results
// are queued at issue time and checked by a monitor as the DUT presents them.
module tb_dmem_access_ctrl;
  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          MemRead_i = 1'b0;
  logic          MemWrite_i = 1'b0;
  logic [31:0]   Addr_i = 32'h0;
  logic [31:0]   WrData_i = 32'h0;
  logic          stall_o;
  logic [31:0]   RdData_o;
  logic          RdValid_o;
  logic          err_o;
  logic [CW-1:0] rd_cnt_o;
  logic [CW-1:0] wr_cnt_o;

  dmem_access_ctrl_if mif();

  dmem_access_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Addr_i(Addr_i), .WrData_i(WrData_i),
    .stall_o(stall_o), .RdData_o(RdData_o), .RdValid_o(RdValid_o),
    .err_o(err_o), .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o),
    .mem_if(mif)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  int          req_cyc = 0;
  int          ack_dly = 0;
  logic [31:0] ack_data = 32'h0;
  int          busy_n = 0;
  logic        req_prev = 1'b0;
  req_t        cur = '{1'b0, 32'h0, 32'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks on the ack_dly-th cycle of each request (0 = never).
  initial begin
    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (mif.mem_req_o) busy_n++;
      else busy_n = 0;
      mif.mem_ack_i   = mif.mem_req_o && (ack_dly != 0) && (busy_n == ack_dly);
      mif.mem_rdata_i = mif.mem_ack_i ? ack_data : 32'h0;
    end
  end

  // Monitor: bus requests and read completions against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk_i);
      if (mif.mem_req_o) begin
        req_cyc++;
        if (!req_prev) begin
          if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %h we %b expected no request",
                     mif.mem_addr_o, mif.mem_we_o);
          end else begin
            cur = exp_req.pop_front();
            check("req_we", 32'(mif.mem_we_o), 32'(cur.we));
            check("req_addr", mif.mem_addr_o, cur.addr);
            if (cur.we) check("req_wdata", mif.mem_wdata_o, cur.wdata);
          end
        end else begin
          check("req_stable_addr", mif.mem_addr_o, cur.addr);
          check("req_stable_we", 32'(mif.mem_we_o), 32'(cur.we));
        end
      end
      req_prev = mif.mem_req_o;
      if (RdValid_o) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rdvalid: got data %h expected no read result", RdData_o);
        end else begin
          check("rd_data", RdData_o, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, output int stalls);
    int budget;
    @(posedge clk_i); #1;
    MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; WrData_i = wd;
    stalls = 0;
    budget = 50;
    @(negedge clk_i);
    while (stall_o && budget > 0) begin
      stalls++;
      budget--;
      @(negedge clk_i);
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL stall_bound: got stall still high expected release within 50 cycles");
    end
    @(posedge clk_i); #1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; Addr_i = 32'h0; WrData_i = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall_o), 32'h0);
    check({tag, "_req"}, 32'(mif.mem_req_o), 32'h0);
    check({tag, "_we"}, 32'(mif.mem_we_o), 32'h0);
    check({tag, "_addr"}, mif.mem_addr_o, 32'h0);
    check({tag, "_wdata"}, mif.mem_wdata_o, 32'h0);
    check({tag, "_rdvalid"}, 32'(RdValid_o), 32'h0);
    check({tag, "_rddata"}, RdData_o, 32'h0);
    check({tag, "_err"}, 32'(err_o), 32'h0);
    check({tag, "_rdcnt"}, 32'(rd_cnt_o), 32'h0);
    check({tag, "_wrcnt"}, 32'(wr_cnt_o), 32'h0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int rc;
    do_reset();

    // Read, ack on third BUSY cycle.
    ack_dly = 3; ack_data = 32'hDEADBEEF;
    exp_req.push_back('{1'b0, 32'h10, 32'h0});
    exp_rd.push_back(32'hDEADBEEF);
    req_cyc = 0;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, st);
    check("rd_stall_cycles", 32'(st), 32'd4);
    check("rd_req_cycles", 32'(req_cyc), 32'd3);
    check("rd_cnt_1", 32'(rd_cnt_o), 32'd1);
    check("rd_hold_data", RdData_o, 32'hDEADBEEF);

    // Write, ack on first BUSY cycle; read+write asserted together counts as write.
    ack_dly = 1; ack_data = 32'h0;
    exp_req.push_back('{1'b1, 32'h20, 32'h12345678});
    do_access(1'b1, 1'b1, 32'h20, 32'h12345678, st);
    check("wr_stall_cycles", 32'(st), 32'd2);
    check("wr_cnt_1", 32'(wr_cnt_o), 32'd1);
    check("wr_rd_cnt_unchanged", 32'(rd_cnt_o), 32'd1);
    check("wr_rddata_kept", RdData_o, 32'hDEADBEEF);

    // Read that times out.
    ack_dly = 0;
    exp_req.push_back('{1'b0, 32'h30, 32'h0});
    req_cyc = 0;
    do_access(1'b1, 1'b0, 32'h30, 32'h0, st);
    check("tmo_stall_cycles", 32'(st), 32'd5);
    check("tmo_req_cycles", 32'(req_cyc), 32'd4);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_rddata_zero", RdData_o, 32'h0);
    check("tmo_rd_cnt", 32'(rd_cnt_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #1;
    check("tmo_back_idle_req", 32'(mif.mem_req_o), 32'h0);

    // Misaligned read: no request, no stall, error on next edge.
    do_reset();
    req_cyc = 0;
    @(posedge clk_i); #1;
    MemRead_i = 1'b1; Addr_i = 32'h13;
    @(negedge clk_i);
    check("mis_stall", 32'(stall_o), 32'h0);
    check("mis_err_before", 32'(err_o), 32'h0);
    @(posedge clk_i); #1;
    check("mis_err_after", 32'(err_o), 32'h1);
    MemRead_i = 1'b0; Addr_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    check("mis_no_req", 32'(req_cyc), 32'h0);
    check("mis_err_sticky", 32'(err_o), 32'h1);
    check("mis_rd_cnt", 32'(rd_cnt_o), 32'h0);

    // Reset in the second BUSY cycle.
    do_reset();
    ack_dly = 0;
    exp_req.push_back('{1'b0, 32'h40, 32'h0});
    @(posedge clk_i); #1;
    MemRead_i = 1'b1; Addr_i = 32'h40;
    @(posedge clk_i);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("midbusy");
    MemRead_i = 1'b0; Addr_i = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
    req_cyc = 0;
    repeat (5) @(posedge clk_i);
    #1;
    check("midbusy_no_replay", 32'(req_cyc), 32'h0);
    check("midbusy_rd_cnt", 32'(rd_cnt_o), 32'h0);

    // Five quick reads: counter saturates at 3.
    ack_dly = 1;
    for (int i = 0; i < 5; i++) begin
      ack_data = 32'hA5000000 + 32'(i);
      exp_req.push_back('{1'b0, 32'h100 + 32'(4 * i), 32'h0});
      exp_rd.push_back(32'hA5000000 + 32'(i));
      do_access(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, st);
      rc = (i + 1 > 3) ? 3 : i + 1;
      check("sat_stall_cycles", 32'(st), 32'd2);
      check("sat_rd_cnt", 32'(rd_cnt_o), 32'(rc));
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("req_queue_drained", 32'(exp_req.size()), 32'h0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max cycles BUSY waits for mem_ack_i before abort (range 1..255).
REQ-002 Parameter CNT_W, default 16, width of saturating access counters.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 MemRead_i  input  1  load request from EX/MEM stage register.
REQ-006 MemWrite_i  input  1  store request from EX/MEM stage register.
REQ-007 Addr_i  input  32  byte address (EX/MEM ALU result).
REQ-008 WrData_i  input  32  store data (EX/MEM RS2 data).
REQ-009 stall_o  output  1  hold IF/ID, ID/EX, EX/MEM and PC while high.
REQ-010 RdData_o  output  32  load result to MEM/WB.
REQ-011 RdValid_o  output  1  RdData_o valid this cycle.
REQ-012 mem_req_o  output  1  memory request, level, held until ack or abort.
REQ-013 mem_we_o  output  1  1 = write, 0 = read; stable while mem_req_o high.
REQ-014 mem_addr_o  output  32  word-aligned address; stable while mem_req_o high.
REQ-015 mem_wdata_o  output  32  write data; stable while mem_req_o high.
REQ-016 mem_ack_i  input  1  single-cycle completion from memory; mem_rdata_i valid in same cycle.
REQ-017 mem_rdata_i  input  32  read data.
REQ-018 err_o  output  1  sticky error flag (misalign or timeout).
REQ-019 rd_cnt_o, wr_cnt_o  output  CNT_W each  completed load/store counts, saturating.

Function
REQ-020 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-021 IDLE, access = MemRead_i|MemWrite_i, Addr_i[1:0]==0: latch addr/wdata/we, go BUSY; stall_o high combinationally same cycle.
REQ-022 MemRead_i and MemWrite_i both high: treated as write.
REQ-023 IDLE, access with Addr_i[1:0]!=0: no memory request, err_o set next edge, stall_o low, RdValid_o low, counters unchanged, stay IDLE.
REQ-024 BUSY: mem_req_o high, stall_o high, timeout counter increments each cycle.
REQ-025 BUSY and mem_ack_i: capture mem_rdata_i into RdData_o (reads only), increment matching counter, drop mem_req_o next cycle, go DONE.
REQ-026 BUSY, counter reaches TIMEOUT_CYC without ack: drop mem_req_o, set err_o, RdData_o = 0, no counter increment, go DONE.
REQ-027 DONE: exactly one cycle, stall_o low, RdValid_o high only for completed read, inputs ignored (same instruction still in EX/MEM), then IDLE.
REQ-028 Access latency: request to RdValid_o = ack cycle + 1; minimum 2 cycles stall-free gap-free issue (IDLE, BUSY, DONE) with ack in first BUSY cycle.
REQ-029 mem_ack_i outside BUSY ignored.
REQ-030 RdData_o holds last value until next completed read or abort.
REQ-031 Counters saturate at 2^CNT_W-1; no wrap.
REQ-032 err_o cleared only by reset.

Reset
REQ-033 rst_i low: state IDLE immediately; stall_o, mem_req_o, mem_we_o, RdValid_o, err_o = 0; RdData_o, mem_addr_o, mem_wdata_o = 0; counters = 0.
REQ-034 Reset mid-BUSY: request dropped immediately, no counter increment; access not replayed after release.

Verification
REQ-035 Read Addr_i=0x10, ack after 3 BUSY cycles with rdata 0xDEADBEEF -> stall_o high 4 cycles, RdValid_o high 1 cycle with RdData_o=0xDEADBEEF, rd_cnt_o=1.
REQ-036 Write Addr_i=0x20, WrData_i=0x12345678, ack first BUSY cycle -> mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x12345678, wr_cnt_o=1, RdValid_o never high.
REQ-037 Read Addr_i=0x13 -> mem_req_o never high, stall_o low, err_o=1 next cycle.
REQ-038 Read with no ack, TIMEOUT_CYC=4 -> mem_req_o high 4 cycles, err_o=1, RdData_o=0, rd_cnt_o unchanged, then IDLE.
REQ-039 rst_i low during BUSY cycle 2 -> all outputs 0 asynchronously, no pending request after release.
REQ-040 CNT_W=2, five acked reads -> rd_cnt_o=3 after fourth and fifth.
